// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - two-requester round-robin sequencer for a single-port RAM (optional clear mode: RAM_ARB_CLEAR_EN)
module ram_access_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
`ifdef RAM_ARB_CLEAR_EN
    input  logic              clr,
    output logic              busy,
`endif
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_rd
);

`ifdef RAM_ARB_CLEAR_EN
    typedef enum logic [1:0] {IDLE, ACCESS, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS} state_t;
`endif

    state_t state;
    state_t state_next;
    logic   rr_last;
    logic   grant_any;
    logic   sel;
`ifdef RAM_ARB_CLEAR_EN
    logic   start_clear;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and arbitration decision; clear has priority over both requesters
    always_comb begin
        state_next = state;
        grant_any  = 1'b0;
        sel        = 1'b0;
`ifdef RAM_ARB_CLEAR_EN
        start_clear = 1'b0;
`endif
        case (state)
            IDLE: begin
`ifdef RAM_ARB_CLEAR_EN
                if (clr) begin
                    start_clear = 1'b1;
                    state_next  = CLEAR;
                end else
`endif
                if (req0 || req1) begin
                    grant_any  = 1'b1;
                    sel        = (req0 && req1) ? ~rr_last : req1;
                    state_next = ACCESS;
                end
            end
            ACCESS: state_next = IDLE;
`ifdef RAM_ARB_CLEAR_EN
            CLEAR: begin
                if (ram_addr == {ADDR_W{1'b1}}) begin
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Registered RAM pins, grants and responses; strobes default low every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last  <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_cs   <= 1'b0;
            ram_we   <= 1'b0;
            ram_rd   <= 1'b0;
`ifdef RAM_ARB_CLEAR_EN
            busy     <= 1'b0;
`endif
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            ram_cs  <= 1'b0;
            ram_we  <= 1'b0;
            ram_rd  <= 1'b0;
`ifdef RAM_ARB_CLEAR_EN
            busy    <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef RAM_ARB_CLEAR_EN
                    if (start_clear) begin
                        ram_cs   <= 1'b1;
                        ram_we   <= 1'b1;
                        ram_din  <= '0;
                        ram_addr <= '0;
                        busy     <= 1'b1;
                    end else
`endif
                    if (grant_any) begin
                        rr_last  <= sel;
                        ram_cs   <= 1'b1;
                        ram_addr <= sel ? addr1 : addr0;
                        ram_din  <= sel ? wdata1 : wdata0;
                        ram_we   <= sel ? we1 : we0;
                        ram_rd   <= sel ? ~we1 : ~we0;
                        gnt0     <= ~sel;
                        gnt1     <= sel;
                    end
                end
                ACCESS: begin
                    // gnt1 still marks the owner of the access that ends at this edge
                    if (ram_rd) begin
                        if (gnt1) begin
                            rdata1  <= ram_dout;
                            rvalid1 <= 1'b1;
                        end else begin
                            rdata0  <= ram_dout;
                            rvalid0 <= 1'b1;
                        end
                    end
                end
`ifdef RAM_ARB_CLEAR_EN
                CLEAR: begin
                    if (ram_addr != {ADDR_W{1'b1}}) begin
                        ram_cs   <= 1'b1;
                        ram_we   <= 1'b1;
                        busy     <= 1'b1;
                        ram_addr <= ram_addr + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb/tb_ram_access_arbiter.sv - self-checking bench for ram_access_arbiter
module tb_ram_access_arbiter;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic reset;
    logic req0, we0, req1, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din, ram_dout;
    logic ram_cs, ram_we, ram_rd;
`ifdef RAM_ARB_CLEAR_EN
    logic clr, busy;
`endif

    logic [DATA_W-1:0] ram_mem [DEPTH];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, clocked write
    assign ram_dout = ram_mem[ram_addr];
    always @(posedge clk) if (ram_cs && ram_we) ram_mem[ram_addr] = ram_din;

    ram_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
`ifdef RAM_ARB_CLEAR_EN
        .clr(clr), .busy(busy),
`endif
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_rd(ram_rd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
`ifdef RAM_ARB_CLEAR_EN
        clr = 0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        logic [39:0] obs;
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
        do_reset();
        obs = {gnt0, gnt1, rvalid0, rvalid1, ram_cs, ram_we, ram_rd, ram_addr, ram_din, rdata0, rdata1, 3'b000};
        total++;
        if (obs !== 40'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", obs); end
        req0 = 1; we0 = 0; addr0 = 2;
        tick();
        total++;
        if ({gnt0, gnt1, ram_cs, ram_rd, ram_we, ram_addr} !== {5'b10110, 2'd2}) begin
            bad++; $display("FAIL first_grant got=%b exp=1011010", {gnt0, gnt1, ram_cs, ram_rd, ram_we, ram_addr});
        end
        req0 = 0;
        tick();
        total++;
        if ({rvalid0, rdata0, gnt0, ram_cs} !== {1'b1, 8'h00, 2'b00}) begin
            bad++; $display("FAIL first_read got=%h exp=%h", {rvalid0, rdata0, gnt0, ram_cs}, {1'b1, 8'h00, 2'b00});
        end
        tick();
        total++;
        if (rvalid0 !== 1'b0) begin bad++; $display("FAIL rvalid_pulse got=%b exp=0", rvalid0); end
    endtask

    task automatic test_write_read();
        req1 = 1; we1 = 1; addr1 = 3; wdata1 = 8'hA5;
        tick();
        total++;
        if ({gnt1, gnt0, ram_cs, ram_we, ram_rd, ram_addr, ram_din} !== {5'b10110, 2'd3, 8'hA5}) begin
            bad++; $display("FAIL write_grant got=%h", {gnt1, gnt0, ram_cs, ram_we, ram_rd, ram_addr, ram_din});
        end
        req1 = 0;
        tick();
        total++;
        if ({ram_we, ram_cs, rvalid1, gnt1} !== 4'b0000) begin
            bad++; $display("FAIL write_end got=%b exp=0000", {ram_we, ram_cs, rvalid1, gnt1});
        end
        req0 = 1; we0 = 0; addr0 = 3;
        tick();
        total++;
        if ({gnt0, ram_rd} !== 2'b11) begin bad++; $display("FAIL read_grant got=%b exp=11", {gnt0, ram_rd}); end
        req0 = 0;
        tick();
        total++;
        if ({rvalid0, rdata0} !== {1'b1, 8'hA5}) begin
            bad++; $display("FAIL read_back got=%h exp=1a5", {rvalid0, rdata0});
        end
        tick();
    endtask

    task automatic test_fairness();
        logic [1:0] exp_g;
        do_reset();
        req0 = 1; we0 = 0; addr0 = 0;
        req1 = 1; we1 = 0; addr1 = 1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k % 2 == 1) exp_g = (((k - 1) / 2) % 2 == 0) ? 2'b10 : 2'b01;
            else exp_g = 2'b00;
            total++;
            if ({gnt0, gnt1} !== exp_g) begin
                bad++; $display("FAIL fair_cycle%0d got=%b exp=%b", k, {gnt0, gnt1}, exp_g);
            end
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        req0 = 1; we0 = 1; addr0 = 1; wdata0 = 8'h5A;
        tick();
        total++;
        if ({gnt0, ram_we, ram_cs} !== 3'b111) begin bad++; $display("FAIL mid_pre got=%b exp=111", {gnt0, ram_we, ram_cs}); end
        reset = 1;
        #1;
        total++;
        if ({gnt0, gnt1, ram_cs, ram_we, ram_rd} !== 5'b0) begin
            bad++; $display("FAIL mid_async_drop got=%b exp=00000", {gnt0, gnt1, ram_cs, ram_we, ram_rd});
        end
        req0 = 0;
        tick();
        total++;
        if ({rvalid0, rvalid1} !== 2'b00) begin bad++; $display("FAIL mid_no_rvalid got=%b exp=00", {rvalid0, rvalid1}); end
        reset = 0;
        req0 = 1; we0 = 0; addr0 = 0;
        req1 = 1; we1 = 0; addr1 = 0;
        tick();
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin bad++; $display("FAIL mid_restart_tie got=%b exp=10", {gnt0, gnt1}); end
        idle_inputs();
        tick();
        tick();
    endtask

`ifdef RAM_ARB_CLEAR_EN
    task automatic test_clear();
        do_reset();
        ram_mem[0] = 8'h11; ram_mem[1] = 8'h22; ram_mem[2] = 8'h33; ram_mem[3] = 8'h44;
        clr = 1;
        req0 = 1; we0 = 0; addr0 = 2;
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            clr = 0;
            total++;
            if ({busy, ram_cs, ram_we, gnt0, gnt1, ram_addr, ram_din} !== {5'b11100, k[1:0], 8'h00}) begin
                bad++; $display("FAIL clear_cycle%0d got=%h", k, {busy, ram_cs, ram_we, gnt0, gnt1, ram_addr, ram_din});
            end
        end
        tick();
        total++;
        if ({busy, ram_cs, gnt0} !== 3'b000) begin bad++; $display("FAIL clear_end got=%b exp=000", {busy, ram_cs, gnt0}); end
        tick();
        total++;
        if ({gnt0, ram_addr} !== {1'b1, 2'd2}) begin bad++; $display("FAIL clear_then_grant got=%b", {gnt0, ram_addr}); end
        req0 = 0;
        tick();
        total++;
        if ({rvalid0, rdata0} !== {1'b1, 8'h00}) begin bad++; $display("FAIL clear_readback got=%h exp=100", {rvalid0, rdata0}); end
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if (ram_mem[i] !== 8'h00) begin bad++; $display("FAIL clear_mem%0d got=%h exp=00", i, ram_mem[i]); end
        end
        tick();
    endtask
`endif

    // Reference model state: transaction-level view of arbitration and memory
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] e_rdata [2];
    logic              r_req [2];
    logic              r_we [2];
    logic [ADDR_W-1:0] r_addr [2];
    logic [DATA_W-1:0] r_data [2];

    task automatic test_random();
        logic m_access, m_last, m_owner, m_we;
        logic [ADDR_W-1:0] m_addr, e_addr;
        logic [DATA_W-1:0] m_data, e_din;
        logic [1:0] e_g, e_v;
        logic e_cs, e_we, e_rd;
        logic w;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = DATA_W'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        for (int n = 0; n < 2; n++) begin
            r_req[n] = 0; r_we[n] = 0; r_addr[n] = '0; r_data[n] = '0; e_rdata[n] = '0;
        end
        m_access = 0; m_last = 1; m_owner = 0; m_we = 0; m_addr = '0; m_data = '0;
        e_addr = '0; e_din = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            req0 = r_req[0]; we0 = r_we[0]; addr0 = r_addr[0]; wdata0 = r_data[0];
            req1 = r_req[1]; we1 = r_we[1]; addr1 = r_addr[1]; wdata1 = r_data[1];
            e_g = 2'b00; e_v = 2'b00; e_cs = 0; e_we = 0; e_rd = 0;
            if (m_access) begin
                if (m_we) ref_mem[m_addr] = m_data;
                else begin
                    e_rdata[m_owner] = ref_mem[m_addr];
                    e_v[m_owner] = 1'b1;
                end
                m_access = 0;
            end else if (r_req[0] || r_req[1]) begin
                w = (r_req[0] && r_req[1]) ? ~m_last : r_req[1];
                e_g[w] = 1'b1;
                e_cs = 1; e_we = r_we[w]; e_rd = ~r_we[w];
                e_addr = r_addr[w]; e_din = r_data[w];
                m_last = w; m_access = 1; m_owner = w;
                m_we = r_we[w]; m_addr = r_addr[w]; m_data = r_data[w];
            end
            tick();
            total++;
            if ({gnt0, gnt1, ram_cs, ram_we, ram_rd, rvalid0, rvalid1} !== {e_g[0], e_g[1], e_cs, e_we, e_rd, e_v[0], e_v[1]}) begin
                bad++; $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", cyc,
                    {gnt0, gnt1, ram_cs, ram_we, ram_rd, rvalid0, rvalid1}, {e_g[0], e_g[1], e_cs, e_we, e_rd, e_v[0], e_v[1]});
            end
            total++;
            if ({ram_addr, ram_din} !== {e_addr, e_din}) begin
                bad++; $display("FAIL rand_pins cyc=%0d got=%h exp=%h", cyc, {ram_addr, ram_din}, {e_addr, e_din});
            end
            total++;
            if ({rdata0, rdata1} !== {e_rdata[0], e_rdata[1]}) begin
                bad++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", cyc, {rdata0, rdata1}, {e_rdata[0], e_rdata[1]});
            end
            for (int n = 0; n < 2; n++) begin
                if (e_g[n] || (!r_req[n] && ($urandom_range(0, 2) == 0))) begin
                    r_req[n] = e_g[n] ? ($urandom_range(0, 1) == 1) : 1'b1;
                    r_we[n] = $urandom_range(0, 1) == 1;
                    r_addr[n] = ADDR_W'($urandom);
                    r_data[n] = DATA_W'($urandom);
                end
            end
        end
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_fairness();
        test_reset_mid_access();
`ifdef RAM_ARB_CLEAR_EN
        test_clear();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
